// File: rtl/seg_scan_capture_if.sv
// Frame delivery bus for seg_scan_capture: one decoded scan frame per
// valid/ready transfer.
interface seg_scan_capture_if #(
  parameter int NDIG = 4
);
  logic                frame_valid;
  logic                frame_ready;
  logic [4*NDIG-1:0]   digits;
  logic [NDIG-1:0]     blank_mask;
  logic [NDIG-1:0]     err_mask;
  logic                overrun;

  modport master (
    output frame_valid, digits, blank_mask, err_mask, overrun,
    input  frame_ready
  );

  modport slave (
    input  frame_valid, digits, blank_mask, err_mask, overrun,
    output frame_ready
  );
endinterface

// File: rtl/seg_scan_capture.sv
// Recovers BCD digits from a multiplexed active-low seven-segment bus and
// delivers each complete scan frame over a valid/ready handshake.
module seg_scan_capture #(
  parameter int NDIG          = 4,
  parameter int STABLE_CYCLES = 8,
  parameter int CNT_W         = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [6:0]        seg_n,
  input  logic [NDIG-1:0]   an_n,
  seg_scan_capture_if.master frame
);

  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CNT_W-1:0] STABLE_C = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);

  typedef enum logic [1:0] {HUNT, SETTLE, HELD} state_t;

  state_t            r_state, w_state_next;
  logic [6:0]        r_seg_m, r_seg_s;
  logic [NDIG-1:0]   r_an_m, r_an_s;
  logic [NDIG+6:0]   r_prev;
  logic [NDIG+6:0]   w_pair;
  logic [CNT_W-1:0]  r_cnt, w_cnt_next;
  logic              w_capture, w_restart, w_same, w_legal;
  logic [IW-1:0]     w_slot;
  int unsigned       w_zeros;
  logic [5:0]        w_dec;

  logic [4*NDIG-1:0] r_sh_dig;
  logic [NDIG-1:0]   r_sh_blank, r_sh_err, r_captured, w_slot_bit;
  logic              w_offer, r_pending;

  // Returns {err, blank, nibble} for one active-low segment pattern.
  function automatic logic [5:0] decode(input logic [6:0] s);
    case (s)
      7'b0000001: decode = 6'b00_0000;
      7'b1001111: decode = 6'b00_0001;
      7'b0010010: decode = 6'b00_0010;
      7'b0000110: decode = 6'b00_0011;
      7'b1001100: decode = 6'b00_0100;
      7'b0100100: decode = 6'b00_0101;
      7'b0100000: decode = 6'b00_0110;
      7'b0001111: decode = 6'b00_0111;
      7'b0000000: decode = 6'b00_1000;
      7'b0000100: decode = 6'b00_1001;
      7'b1111111: decode = 6'b01_1111;
      default:    decode = 6'b10_1110;
    endcase
  endfunction

  assign w_pair  = {r_an_s, r_seg_s};
  assign w_same  = (w_pair == r_prev);
  assign w_dec   = decode(r_seg_s);
  assign w_offer = &r_captured;

  always_comb begin
    w_zeros    = 0;
    w_slot     = '0;
    w_slot_bit = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (!r_an_s[i]) begin
        w_zeros = w_zeros + 1;
        w_slot  = IW'(i);
      end
    end
    w_legal = (w_zeros == 1);
    w_slot_bit[w_slot] = 1'b1;
  end

  // Any new legal sample starts a fresh run of length one.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_capture    = 1'b0;
    w_restart    = 1'b0;
    case (r_state)
      HUNT: w_restart = 1'b1;
      SETTLE: begin
        if (w_same && w_legal) begin
          w_cnt_next = r_cnt + ONE_C;
          if (w_cnt_next == STABLE_C) begin
            w_capture    = 1'b1;
            w_state_next = HELD;
          end
        end else begin
          w_restart = 1'b1;
        end
      end
      HELD: if (!(w_same && w_legal)) w_restart = 1'b1;
      default: w_state_next = HUNT;
    endcase
    if (w_restart) begin
      if (w_legal) begin
        w_cnt_next = ONE_C;
        if (STABLE_C == ONE_C) begin
          w_capture    = 1'b1;
          w_state_next = HELD;
        end else begin
          w_state_next = SETTLE;
        end
      end else begin
        w_cnt_next   = '0;
        w_state_next = HUNT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_seg_m <= '1;
      r_seg_s <= '1;
      r_an_m  <= '1;
      r_an_s  <= '1;
      r_prev  <= '1;
      r_state <= HUNT;
      r_cnt   <= '0;
    end else begin
      r_seg_m <= seg_n;
      r_seg_s <= r_seg_m;
      r_an_m  <= an_n;
      r_an_s  <= r_an_m;
      r_prev  <= w_pair;
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sh_dig   <= '1;
      r_sh_blank <= '1;
      r_sh_err   <= '0;
      r_captured <= '0;
    end else begin
      r_captured <= (w_offer ? '0 : r_captured) | (w_capture ? w_slot_bit : '0);
      if (w_capture) begin
        r_sh_dig[4*w_slot +: 4] <= w_dec[3:0];
        r_sh_blank[w_slot]      <= w_dec[4];
        r_sh_err[w_slot]        <= w_dec[5];
      end
    end
  end

  // A completed frame loads only when the output slot is free or being drained.
  always_ff @(posedge clk) begin
    if (!reset) begin
      frame.frame_valid <= 1'b0;
      frame.digits      <= '1;
      frame.blank_mask  <= '1;
      frame.err_mask    <= '0;
      frame.overrun     <= 1'b0;
      r_pending         <= 1'b0;
    end else if (w_offer) begin
      if (!frame.frame_valid || frame.frame_ready) begin
        frame.frame_valid <= 1'b1;
        frame.digits      <= r_sh_dig;
        frame.blank_mask  <= r_sh_blank;
        frame.err_mask    <= r_sh_err;
        frame.overrun     <= r_pending;
        r_pending         <= 1'b0;
      end else begin
        r_pending <= 1'b1;
      end
    end else if (frame.frame_valid && frame.frame_ready) begin
      frame.frame_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seg_scan_capture.sv
// Scoreboard bench for seg_scan_capture: a run-length reference model predicts
// captured frames; a negedge monitor pops and compares delivered frames.
module tb_seg_scan_capture;

  localparam int NDIG   = 4;
  localparam int STABLE = 8;

  typedef struct packed {
    logic [15:0] digits;
    logic [3:0]  blank;
    logic [3:0]  err;
    logic        overrun;
  } frame_t;

  logic        clock = 1'b0;
  logic        reset;
  logic [6:0]  segN;
  logic [3:0]  anN;

  seg_scan_capture_if #(.NDIG(NDIG)) frameIf();

  seg_scan_capture #(.NDIG(NDIG), .STABLE_CYCLES(STABLE), .CNT_W(4)) dut (
    .clk   (clock),
    .reset (reset),
    .seg_n (segN),
    .an_n  (anN),
    .frame (frameIf)
  );

  always #5 clock = ~clock;

  logic [6:0] segTable [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                7'b0000000, 7'b0000100};
  int durTable [9] = '{1, 2, 3, 5, 7, 8, 12, 16, 20};

  frame_t      sbQueue[$];
  int          assertCount = 0;
  int          failCount   = 0;

  logic [3:0]  mDig [4];
  logic [3:0]  mBlank, mErr, mCaptured;
  logic        mPending, mOccupied, readyLvl;
  logic [10:0] prevPair;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [5:0] refDecode(input logic [6:0] s);
    refDecode = 6'b10_1110;
    if (s == 7'h7F) refDecode = 6'b01_1111;
    for (int d = 0; d < 10; d++)
      if (segTable[d] == s) refDecode = {2'b00, 4'(d)};
  endfunction

  task automatic modelComplete();
    frame_t f;
    if (mOccupied) begin
      mPending = 1'b1;
    end else begin
      f.digits  = {mDig[3], mDig[2], mDig[1], mDig[0]};
      f.blank   = mBlank;
      f.err     = mErr;
      f.overrun = mPending;
      sbQueue.push_back(f);
      mPending  = 1'b0;
      mOccupied = !readyLvl;
    end
  endtask

  task automatic modelCapture(input logic [3:0] an, input logic [6:0] seg);
    logic [5:0] d;
    int slot;
    slot = 0;
    for (int i = 0; i < 4; i++) if (!an[i]) slot = i;
    d = refDecode(seg);
    mDig[slot]   = d[3:0];
    mBlank[slot] = d[4];
    mErr[slot]   = d[5];
    mCaptured[slot] = 1'b1;
    if (mCaptured == 4'hF) begin
      mCaptured = 4'h0;
      modelComplete();
    end
  endtask

  // A digit is taken once its pattern has been held STABLE cycles in one run.
  task automatic applyStimulus(input logic [3:0] an, input logic [6:0] seg, input int dur);
    anN  = an;
    segN = seg;
    if ($countones(~an) == 1 && dur >= STABLE && {an, seg} != prevPair)
      modelCapture(an, seg);
    prevPair = {an, seg};
    repeat (dur) @(posedge clock);
    #1;
  endtask

  task automatic setReady(input logic v);
    applyStimulus(4'hF, 7'h7F, 15);
    readyLvl = v;
    frameIf.frame_ready = v;
    if (v) mOccupied = 1'b0;
  endtask

  task automatic scanFrame(input logic [6:0] s0, input logic [6:0] s1,
                           input logic [6:0] s2, input logic [6:0] s3, input int dur);
    applyStimulus(4'b1110, s0, dur);
    applyStimulus(4'b1101, s1, dur);
    applyStimulus(4'b1011, s2, dur);
    applyStimulus(4'b0111, s3, dur);
  endtask

  task automatic checkResetState();
    checkOutput("reset.valid",   32'(frameIf.frame_valid), 32'h0);
    checkOutput("reset.digits",  32'(frameIf.digits),      32'hFFFF);
    checkOutput("reset.blank",   32'(frameIf.blank_mask),  32'hF);
    checkOutput("reset.err",     32'(frameIf.err_mask),    32'h0);
    checkOutput("reset.overrun", 32'(frameIf.overrun),     32'h0);
  endtask

  task automatic doReset();
    reset = 1'b0;
    @(posedge clock);
    #1;
    reset     = 1'b1;
    mCaptured = 4'h0;
    mPending  = 1'b0;
    mOccupied = 1'b0;
    prevPair  = 11'h7FF;
    checkResetState();
  endtask

  // Monitor: pop on every transfer, and require held frames to stay stable.
  frame_t snap;
  logic   holdActive = 1'b0;
  always @(negedge clock) begin
    frame_t exp;
    if (reset && frameIf.frame_valid) begin
      if (frameIf.frame_ready) begin
        holdActive <= 1'b0;
        if (sbQueue.size() == 0) begin
          checkOutput("frame.unexpected", 32'h1, 32'h0);
        end else begin
          exp = sbQueue.pop_front();
          checkOutput("frame.digits",  32'(frameIf.digits),     32'(exp.digits));
          checkOutput("frame.blank",   32'(frameIf.blank_mask), 32'(exp.blank));
          checkOutput("frame.err",     32'(frameIf.err_mask),   32'(exp.err));
          checkOutput("frame.overrun", 32'(frameIf.overrun),    32'(exp.overrun));
        end
      end else if (holdActive) begin
        checkOutput("hold.stable", 32'({frameIf.digits, frameIf.blank_mask,
                    frameIf.err_mask, frameIf.overrun}),
                    32'({snap.digits, snap.blank, snap.err, snap.overrun}));
      end else begin
        snap       <= '{frameIf.digits, frameIf.blank_mask, frameIf.err_mask, frameIf.overrun};
        holdActive <= 1'b1;
      end
    end else begin
      holdActive <= 1'b0;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [3:0] an;
    logic [6:0] seg;
    int         pick, dur;

    reset = 1'b0;
    segN  = 7'h7F;
    anN   = 4'hF;
    frameIf.frame_ready = 1'b1;
    readyLvl  = 1'b1;
    mCaptured = 4'h0;
    mPending  = 1'b0;
    mOccupied = 1'b0;
    prevPair  = 11'h7FF;
    for (int i = 0; i < 4; i++) mDig[i] = 4'hF;
    mBlank = 4'hF;
    mErr   = 4'h0;
    repeat (3) @(posedge clock);
    #1;
    checkResetState();
    reset = 1'b1;

    $display("[TB] basic scan 1,2,3,4");
    scanFrame(7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100, 20);

    $display("[TB] short hold of digit0 is ignored");
    applyStimulus(4'b1110, 7'b0000001, 5);
    applyStimulus(4'b1101, 7'b0100100, 12);
    applyStimulus(4'b1011, 7'b0100000, 12);
    applyStimulus(4'b0111, 7'b0001111, 12);
    applyStimulus(4'b1110, 7'b0000001, 12);

    $display("[TB] blank and unrecognised patterns");
    scanFrame(7'b0000000, 7'b0000100, 7'b1111111, 7'b1010101, 14);

    $display("[TB] backpressure and overrun");
    setReady(1'b0);
    scanFrame(7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 12);
    scanFrame(7'b0100000, 7'b0100000, 7'b0100000, 7'b0100000, 12);
    setReady(1'b1);
    scanFrame(7'b1001100, 7'b0100100, 7'b0000110, 7'b0010010, 12);
    scanFrame(7'b0000100, 7'b0000000, 7'b0001111, 7'b0100000, 12);

    $display("[TB] two anodes low is illegal");
    applyStimulus(4'b1110, 7'b0000110, 12);
    applyStimulus(4'b1101, 7'b0000001, 12);
    applyStimulus(4'b1100, 7'b0000000, 50);
    applyStimulus(4'b1011, 7'b1001111, 12);
    applyStimulus(4'b0111, 7'b1001111, 12);

    $display("[TB] reset discards partial frame");
    applyStimulus(4'b1110, 7'b0001111, 12);
    applyStimulus(4'b1101, 7'b0001111, 12);
    doReset();
    scanFrame(7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 12);

    $display("[TB] randomized scan");
    for (int item = 0; item < 240; item++) begin
      if (item % 60 == 59) setReady(~readyLvl);
      do begin
        if ($urandom_range(0, 9) == 0) begin
          do an = 4'($urandom_range(0, 15)); while ($countones(~an) == 1);
        end else begin
          an = ~(4'b0001 << $urandom_range(0, 3));
        end
        pick = $urandom_range(0, 9);
        if (pick < 8)       seg = segTable[$urandom_range(0, 9)];
        else if (pick == 8) seg = 7'h7F;
        else                seg = 7'($urandom_range(0, 127));
      end while ({an, seg} == prevPair);
      dur = durTable[$urandom_range(0, 8)];
      applyStimulus(an, seg, dur);
    end

    setReady(1'b1);
    applyStimulus(4'hF, 7'h7F, 30);
    checkOutput("scoreboard.empty", 32'(sbQueue.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
